// File: rtl/fsm_pkg.sv
// Shared types and constants for the three-in-a-row run detector.
package fsm_pkg;

    localparam int FSM_RUN_LEN = 3;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } fsm_state_t;

    // The state code equals the number of 1s seen so far, so detection is reached at the run length.
    localparam fsm_state_t FSM_DET_STATE = fsm_state_t'(FSM_RUN_LEN[1:0]);

endpackage

// File: rtl/fsm.sv
// Moore run detector: Y is high while three or more consecutive 1s have been sampled on X.
// Optional debug port state_o is present only when FSM_STATE_OUT_EN is defined.
module fsm
    import fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       X,
    output logic       Y
`ifdef FSM_STATE_OUT_EN
    ,
    output logic [1:0] state_o
`endif
);

    fsm_state_t state_q;
    fsm_state_t state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Any 0 restarts the count; consecutive 1s climb and saturate in the detect state.
    always_comb begin
        state_d = S0;
        Y       = 1'b0;
        if (X) begin
            case (state_q)
                S0:      state_d = S1;
                S1:      state_d = S2;
                S2:      state_d = S3;
                S3:      state_d = S3;
                default: state_d = S0;
            endcase
        end
        Y = (state_q == FSM_DET_STATE);
    end

`ifdef FSM_STATE_OUT_EN
    assign state_o = state_q;
`else
    // Without the debug port the state is observed only through Y.
`endif

endmodule

// File: tb/tb_fsm.sv
// Scoreboard bench for the run detector: stimulus queues expected values, a monitor checks them.
module tb_fsm;

    typedef struct {
        int         due;
        logic       y;
        logic [1:0] st;
        string      tag;
    } expItem_t;

    logic clk;
    logic reset;
    logic X;
    logic Y;
`ifdef FSM_STATE_OUT_EN
    logic [1:0] state_o;
`endif

    expItem_t sb[$];
    int       edgeCnt = 0;
    int       checks  = 0;
    int       errors  = 0;
    event     checkNow;

    fsm dut (
        .clk     (clk),
        .reset   (reset),
        .X       (X),
        .Y       (Y)
`ifdef FSM_STATE_OUT_EN
        ,
        .state_o (state_o)
`endif
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input expItem_t it);
        checks++;
        if (Y !== it.y) begin
            errors++;
            $display("[TB] FAIL %s: Y=%b expected %b at %0t", it.tag, Y, it.y, $time);
        end
`ifdef FSM_STATE_OUT_EN
        checks++;
        if (state_o !== it.st) begin
            errors++;
            $display("[TB] FAIL %s_state: state_o=%b expected %b at %0t", it.tag, state_o, it.st, $time);
        end
`endif
    endtask

    // Drive X mid-cycle; the expectation applies after the next rising edge samples it.
    task automatic applyStimulus(input logic x, input logic expY, input logic [1:0] expSt, input string tag);
        @(negedge clk);
        X = x;
        sb.push_back('{due: edgeCnt + 1, y: expY, st: expSt, tag: tag});
    endtask

    task automatic pushImmediate(input logic expY, input logic [1:0] expSt, input string tag);
        sb.push_back('{due: 0, y: expY, st: expSt, tag: tag});
        ->checkNow;
    endtask

    // Monitor: checks every queued expectation whose sampling edge has already occurred.
    initial begin
        forever begin
            @(negedge clk or checkNow);
            while (sb.size() > 0 && sb[0].due <= edgeCnt) begin
                checkOutput(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       xs2 [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       ys2 [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0] ss2 [10] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
        logic       xs3 [7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0] ss3 [7]  = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};

        reset = 1'b0;
        X     = 1'b0;
        #1;
        pushImmediate(1'b0, 2'b00, "rst_before_edge");
        #24;
        pushImmediate(1'b0, 2'b00, "rst_after_edge");
        #5;
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(xs2[i], ys2[i], ss2[i], $sformatf("run_%0d", i));
        end

        for (int i = 0; i < 7; i++) begin
            applyStimulus(xs3[i], 1'b0, ss3[i], $sformatf("broken_%0d", i));
        end

        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, (i >= 3) ? 1'b1 : 1'b0,
                          (i >= 3) ? 2'b11 : 2'(i), $sformatf("hold_%0d", i));
        end

        // Mid-cycle reset pulse while detecting, with X still high.
        @(negedge clk);
        #5;
        reset = 1'b0;
        #1;
        pushImmediate(1'b0, 2'b00, "async_drop");
        #4;
        reset = 1'b1;
        sb.push_back('{due: edgeCnt + 1, y: 1'b0, st: 2'b01, tag: "rel_1"});
        applyStimulus(1'b1, 1'b0, 2'b10, "rel_2");
        applyStimulus(1'b1, 1'b1, 2'b11, "rel_3");

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations unchecked, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
